// File: rtl/multiply.sv
// Sequential shift-add unsigned multiplier, Y = A * B at full 2W-bit width.
// Latency W cycles from accept to Out_Valid; result held in Done until Out_Ready, one operand pair in flight.
module multiply #(
    parameter int W = 32
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic [W-1:0]   A,
    input  logic [W-1:0]   B,
    input  logic           In_Valid,
    output logic           In_Ready,
    output logic [2*W-1:0] Y,
    output logic           Out_Valid,
    input  logic           Out_Ready
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc_next;

    // Partial product for the current multiplier bit, shared by the accumulator and the final Y load.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            Y      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid) begin
                        mcand  <= {{W{1'b0}}, A};
                        mplier <= B;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // Fixed W iterations regardless of operand values; no early exit.
                    if (cnt == CW'(W - 1)) begin
                        Y     <= acc_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (Out_Ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign In_Ready  = (state == IDLE);
    assign Out_Valid = (state == DONE);

endmodule

// File: tb/tb_multiply.sv
// Directed and randomized checks of the sequential multiplier at W=32.
module tb_multiply;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [63:0] Y;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;

    multiply #(.W(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .A         (A),
        .B         (B),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Y         (Y),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (!Reset && Out_Valid && Out_Ready) hs_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Wait for In_Ready, then hold In_Valid for exactly one edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!In_Ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("start_timeout", 64'd1, 64'd0);
        A = a;
        B = b;
        In_Valid = 1'b1;
        tick();
        In_Valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until Out_Valid appears.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!Out_Valid && lat < 200) begin
            tick();
            lat++;
        end
        if (lat >= 200) check("done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int lat;
        int hs0;
        int seen;
        logic [31:0] ra, rb;
        logic [63:0] ref_y;

        tick();
        tick();
        Reset = 1'b0;
        check("rst_in_ready", {63'd0, In_Ready}, 64'd1);
        check("rst_out_valid", {63'd0, Out_Valid}, 64'd0);
        check("rst_y", Y, 64'd0);

        // 3*5 with Out_Ready high; In_Valid held on the Done->Idle edge must not be accepted.
        Out_Ready = 1'b1;
        start(32'd3, 32'd5);
        check("accept_drops_ready", {63'd0, In_Ready}, 64'd0);
        wait_done(lat);
        check("lat_3x5", 64'(lat), 64'd32);
        check("y_3x5", Y, 64'd15);
        In_Valid = 1'b1;
        A = 32'd100;
        B = 32'd100;
        tick();
        check("ready_after_done", {63'd0, In_Ready}, 64'd1);
        check("ovalid_after_done", {63'd0, Out_Valid}, 64'd0);
        In_Valid = 1'b0;
        tick();
        check("y_kept_in_idle", Y, 64'd15);

        start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat);
        check("lat_max", 64'(lat), 64'd32);
        check("y_max", Y, 64'hFFFF_FFFE_0000_0001);
        tick();

        start(32'd0, 32'hDEAD_BEEF);
        wait_done(lat);
        check("lat_zero", 64'(lat), 64'd32);
        check("y_zero", Y, 64'd0);
        tick();

        // Backpressure: hold Done for 20 cycles while inputs wiggle.
        Out_Ready = 1'b0;
        start(32'h1234_5678, 32'h9ABC_DEF0);
        wait_done(lat);
        check("lat_hold", 64'(lat), 64'd32);
        for (int i = 0; i < 20; i++) begin
            In_Valid = i[0];
            A = 32'd7 + 32'(i);
            B = 32'd11 * 32'(i);
            tick();
            check("hold_y", Y, 64'h0B00_EA4E_242D_2080);
            check("hold_ovalid", {63'd0, Out_Valid}, 64'd1);
            check("hold_iready", {63'd0, In_Ready}, 64'd0);
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        tick();
        check("hold_release", {63'd0, In_Ready}, 64'd1);

        // Abort at Run iteration 10 with In_Valid on the reset edge.
        start(32'd1000, 32'd2000);
        for (int i = 0; i < 10; i++) tick();
        Reset = 1'b1;
        In_Valid = 1'b1;
        A = 32'd55;
        B = 32'd66;
        tick();
        Reset = 1'b0;
        In_Valid = 1'b0;
        check("abort_iready", {63'd0, In_Ready}, 64'd1);
        check("abort_ovalid", {63'd0, Out_Valid}, 64'd0);
        check("abort_y", Y, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Out_Valid) seen++;
        end
        check("abort_no_ovalid", 64'(seen), 64'd0);
        start(32'd7, 32'd9);
        wait_done(lat);
        check("lat_7x9", 64'(lat), 64'd32);
        check("y_7x9", Y, 64'd63);
        tick();

        // Random back-to-back pairs with random output backpressure.
        hs0 = hs_cnt;
        for (int k = 0; k < 1000; k++) begin
            int n;
            ra = $urandom();
            rb = $urandom();
            ref_y = {32'd0, ra} * {32'd0, rb};
            Out_Ready = 1'b0;
            start(ra, rb);
            wait_done(lat);
            check("rand_y", Y, ref_y);
            n = 0;
            while (n < 50) begin
                Out_Ready = ($urandom_range(0, 1) == 1);
                tick();
                n++;
                if (In_Ready) break;
                check("rand_hold", Y, ref_y);
            end
            if (n >= 50) check("rand_release_timeout", 64'd1, 64'd0);
        end
        Out_Ready = 1'b0;
        tick();
        check("rand_hs_count", 64'(hs_cnt - hs0), 64'd1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
